float_split: RTL and testbench

//  Unpacks an IEEE-style float into sign / extended signed exponent / mantissa with explicit

---
 rtl/float_split.sv | 133 +++++++++++++
 tb/tb_float_split.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/float_split.sv
// float_split: unpacks {sign, exp field, fraction} into sign / signed biased exponent / mantissa
//   with an explicit hidden bit. Subnormals are normalised one bit per cycle so that
//   man[MAN_WIDTH] is always set for nonzero values.
// Latency: 1 cycle from accept to out_valid for zero/normal/inf/nan; 1 + (1 + leading zeros of
//   the fraction) cycles for subnormals.
// Backpressure: the result is held stable while out_valid && !out_ready. in_ready is low while
//   normalising, and also while a result is held and not yet taken. A new input is accepted in
//   the same cycle the held result is taken, giving one result per cycle for non-subnormals.
// Ports:
//   clk, reset                 clock; synchronous active-high reset
//   in_valid/in_ready/in       packed float input handshake
//   out_valid/out_ready        result handshake
//   sign, exp, man             unpacked fields; man = {2'b00, hidden, fraction}
//   is_zero, is_inf, is_nan    mutually exclusive classification flags
module float_split #(
  parameter int EXP_WIDTH = 8,
  parameter int MAN_WIDTH = 23,
  localparam int FLOAT_WIDTH = 1 + EXP_WIDTH + MAN_WIDTH
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [FLOAT_WIDTH-1:0] in,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   sign,
  output logic [EXP_WIDTH+1:0]   exp,
  output logic [MAN_WIDTH+2:0]   man,
  output logic                   is_zero,
  output logic                   is_inf,
  output logic                   is_nan
);

  typedef enum logic [1:0] {IDLE, NORM, DONE} state_t;

  localparam logic [EXP_WIDTH+1:0] EXP_ONE = {{(EXP_WIDTH+1){1'b0}}, 1'b1};

  state_t                 state_q, state_d;
  logic                   sign_q, sign_d;
  logic [EXP_WIDTH+1:0]   exp_q, exp_d;
  logic [MAN_WIDTH+2:0]   man_q, man_d;
  logic                   is_zero_q, is_zero_d;
  logic                   is_inf_q, is_inf_d;
  logic                   is_nan_q, is_nan_d;

  logic [EXP_WIDTH-1:0]   e_fld;
  logic [MAN_WIDTH-1:0]   f_fld;
  logic                   accept;

  assign e_fld     = in[FLOAT_WIDTH-2 -: EXP_WIDTH];
  assign f_fld     = in[MAN_WIDTH-1:0];
  assign in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == DONE);

  always_comb begin
    state_d   = state_q;
    sign_d    = sign_q;
    exp_d     = exp_q;
    man_d     = man_q;
    is_zero_d = is_zero_q;
    is_inf_d  = is_inf_q;
    is_nan_d  = is_nan_q;

    case (state_q)
      IDLE, DONE: begin
        if (accept) begin
          sign_d    = in[FLOAT_WIDTH-1];
          is_zero_d = 1'b0;
          is_inf_d  = 1'b0;
          is_nan_d  = 1'b0;
          state_d   = DONE;
          if ((e_fld == '0) && (f_fld == '0)) begin
            exp_d     = '0;
            man_d     = '0;
            is_zero_d = 1'b1;
          end else if (e_fld != '0) begin
            // Normal, inf and nan all carry the hidden bit and the raw exponent field.
            exp_d    = {2'b00, e_fld};
            man_d    = {2'b00, 1'b1, f_fld};
            is_inf_d = (&e_fld) && (f_fld == '0);
            is_nan_d = (&e_fld) && (f_fld != '0);
          end else begin
            // Subnormal: true exponent is 1 with no hidden bit; shift until the hidden
            // position fills, decrementing the exponent once per shift.
            exp_d   = EXP_ONE;
            man_d   = {2'b00, 1'b0, f_fld};
            state_d = NORM;
          end
        end else if (state_q == DONE && out_ready) begin
          state_d = IDLE;
        end
      end
      NORM: begin
        man_d = man_q << 1;
        exp_d = exp_q - EXP_ONE;
        if (man_d[MAN_WIDTH]) begin
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      sign_q    <= 1'b0;
      exp_q     <= '0;
      man_q     <= '0;
      is_zero_q <= 1'b0;
      is_inf_q  <= 1'b0;
      is_nan_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      sign_q    <= sign_d;
      exp_q     <= exp_d;
      man_q     <= man_d;
      is_zero_q <= is_zero_d;
      is_inf_q  <= is_inf_d;
      is_nan_q  <= is_nan_d;
    end
  end

  assign sign    = sign_q;
  assign exp     = exp_q;
  assign man     = man_q;
  assign is_zero = is_zero_q;
  assign is_inf  = is_inf_q;
  assign is_nan  = is_nan_q;

endmodule

// File: tb/tb_float_split.sv
// tb_float_split: randomized and directed stimulus for float_split (FP32) with a
//   queue-based scoreboard; expected fields come from an arithmetic reference model,
//   and every non-NaN result is also recombined into a float and compared to the input.
module tb_float_split;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_dat = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        sign;
  logic [9:0]  exp;
  logic [25:0] man;
  logic        is_zero, is_inf, is_nan;

  float_split #(.EXP_WIDTH(8), .MAN_WIDTH(23)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in(in_dat),
    .out_valid(out_valid), .out_ready(out_ready),
    .sign(sign), .exp(exp), .man(man),
    .is_zero(is_zero), .is_inf(is_inf), .is_nan(is_nan)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] in_w;
    logic        s;
    logic [9:0]  e;
    logic [25:0] m;
    logic        z;
    logic        i;
    logic        n;
    int          lat;
    int          acc;
  } sb_t;

  sb_t sbq[$];
  int  cyc = 0;
  int  checks = 0;
  int  failures = 0;
  bit  fresh = 1'b1;
  bit  rand_rdy = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference: value = (-1)^s * 0.F * 2^(1-bias) for subnormals; normalise by moving the
  // leading one of F up to the hidden position and lowering the exponent accordingly.
  function automatic sb_t model(input logic [31:0] x);
    sb_t r;
    logic [7:0]  ef;
    logic [22:0] f;
    int msb, k;
    r = '0;
    r.in_w = x;
    r.s = x[31];
    r.lat = 1;
    ef = x[30:23];
    f = x[22:0];
    if (ef == 8'd0 && f == 23'd0) begin
      r.z = 1'b1;
    end else if (ef != 8'd0) begin
      r.e = {2'b00, ef};
      r.m = {3'b001, f};
      r.i = (ef == 8'hFF) && (f == 23'd0);
      r.n = (ef == 8'hFF) && (f != 23'd0);
    end else begin
      msb = 0;
      for (int b = 0; b < 23; b++) if (f[b]) msb = b;
      k = 23 - msb;
      r.m = 26'(f) << k;
      r.e = 10'(1 - k);
      r.lat = 1 + k;
    end
    return r;
  endfunction

  // Packs unpacked fields back into a float, denormalising when the exponent is below 1.
  function automatic logic [31:0] combine(input logic s, input logic [9:0] e,
                                          input logic [25:0] m, input logic z);
    int se;
    logic [25:0] sh;
    se = int'($signed(e));
    if (z) return {s, 31'd0};
    if (se >= 1) return {s, e[7:0], m[22:0]};
    sh = m >> (1 - se);
    return {s, 8'd0, sh[22:0]};
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  // Monitor / scoreboard: compares whenever out_valid (also proving held results stay stable),
  // pops on handshake, and records accepts as they are seen on the input side.
  initial begin
    sb_t it;
    forever begin
      @(negedge clk);
      if (!reset && out_valid) begin
        if (sbq.size() == 0) begin
          chk("unexpected_out_valid", 64'(out_valid), 64'd0);
        end else begin
          it = sbq[0];
          chk($sformatf("fields_in_%08h", it.in_w),
              64'({sign, exp, man, is_zero, is_inf, is_nan}),
              64'({it.s, it.e, it.m, it.z, it.i, it.n}));
          if (fresh) begin
            chk($sformatf("latency_in_%08h", it.in_w), 64'(cyc - it.acc), 64'(it.lat));
            fresh = 1'b0;
          end
          if (out_ready) begin
            if (!it.n)
              chk($sformatf("roundtrip_in_%08h", it.in_w),
                  64'(combine(sign, exp, man, is_zero)), 64'(it.in_w));
            void'(sbq.pop_front());
            fresh = 1'b1;
          end
        end
      end
      if (!reset && in_valid && in_ready) begin
        it = model(in_dat);
        it.acc = cyc;
        sbq.push_back(it);
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
    end
  end

  task automatic send(input logic [31:0] x);
    int n;
    in_dat = x;
    in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      $display("FAIL accept_timeout in=%08h waited=%0d limit=200", x, n);
      failures++;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "accept timeout");
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Sends one value with out_ready low, measures latency to out_valid, checks the held
  // outputs against literal values, then releases the result.
  task automatic expect_out(input logic [31:0] x, input int lat, input logic s,
                            input logic [9:0] e, input logic [25:0] m,
                            input logic z, input logic i, input logic n, input int hold);
    int c;
    out_ready = 1'b0;
    send(x);
    c = 1;
    while (!out_valid && c < 100) begin
      @(posedge clk);
      #1;
      c++;
    end
    chk($sformatf("dir_latency_%08h", x), 64'(c), 64'(lat));
    chk($sformatf("dir_fields_%08h", x), 64'({sign, exp, man, is_zero, is_inf, is_nan}),
        64'({s, e, m, z, i, n}));
    for (int h = 0; h < hold; h++) begin
      @(posedge clk);
      #1;
      chk($sformatf("hold_valid_%0d", h), 64'(out_valid), 64'd1);
      chk($sformatf("hold_in_ready_%0d", h), 64'(in_ready), 64'd0);
      chk($sformatf("hold_fields_%0d", h), 64'({sign, exp, man, is_zero, is_inf, is_nan}),
          64'({s, e, m, z, i, n}));
    end
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  initial begin
    int t0, n;
    logic [31:0] x;
    logic [22:0] f;
    int r;

    repeat (2) @(posedge clk);
    #1;
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_in_ready", 64'(in_ready), 64'd1);
    chk("reset_outputs", 64'({sign, exp, man, is_zero, is_inf, is_nan}), 64'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    expect_out(32'h3F800000, 1, 1'b0, 10'h07F, 26'h0800000, 1'b0, 1'b0, 1'b0, 0);
    release_out();
    expect_out(32'h00000001, 24, 1'b0, 10'h3EA, 26'h0800000, 1'b0, 1'b0, 1'b0, 0);
    release_out();
    expect_out(32'h00400000, 2, 1'b0, 10'h000, 26'h0800000, 1'b0, 1'b0, 1'b0, 0);
    release_out();
    expect_out(32'h80000000, 1, 1'b1, 10'h000, 26'h0000000, 1'b1, 1'b0, 1'b0, 0);
    release_out();
    expect_out(32'h7F800000, 1, 1'b0, 10'h0FF, 26'h0800000, 1'b0, 1'b1, 1'b0, 0);
    release_out();
    expect_out(32'h7FC00000, 1, 1'b0, 10'h0FF, 26'h0C00000, 1'b0, 1'b0, 1'b1, 0);
    release_out();

    // Stall for 3 cycles, then stream 4 normals back to back while the held result drains.
    expect_out(32'hC0490FDB, 1, 1'b1, 10'h080, 26'h0C90FDB, 1'b0, 1'b0, 1'b0, 3);
    out_ready = 1'b1;
    t0 = cyc;
    send(32'h3F800000);
    send(32'h40000000);
    send(32'hBF000000);
    send(32'h42F60000);
    chk("stream_cycles", 64'(cyc - t0), 64'd4);
    @(posedge clk);
    #1;
    chk("stream_drained", 64'(sbq.size()), 64'd0);

    // Reset in the middle of normalising a subnormal discards it.
    send(32'h00000001);
    repeat (5) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    sbq.delete();
    fresh = 1'b1;
    chk("midnorm_reset_out_valid", 64'(out_valid), 64'd0);
    chk("midnorm_reset_in_ready", 64'(in_ready), 64'd1);
    chk("midnorm_reset_outputs", 64'({sign, exp, man, is_zero, is_inf, is_nan}), 64'd0);
    expect_out(32'h40000000, 1, 1'b0, 10'h080, 26'h0800000, 1'b0, 1'b0, 1'b0, 0);
    release_out();

    // Random mix with random backpressure.
    rand_rdy = 1'b1;
    for (int k = 0; k < 4000; k++) begin
      r = $urandom_range(0, 9);
      x = $urandom();
      case (r)
        0: x = {x[31], 31'd0};
        1, 2: begin
          f = 23'($urandom() >> $urandom_range(9, 31));
          if (f == 23'd0) f = 23'd1;
          x = {x[31], 8'd0, f};
        end
        3: x = {x[31], 8'hFF, 23'd0};
        4: begin
          f = x[22:0];
          if (f == 23'd0) f = 23'd1;
          x = {x[31], 8'hFF, f};
        end
        default: ;
      endcase
      send(x);
    end
    rand_rdy = 1'b0;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    n = 0;
    while (sbq.size() != 0 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("final_drain_pending", 64'(sbq.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
